// File: rtl/ct_had_pipetrace_ctrl_pkg.sv
// Shared types and field offsets for the HAD pipe-trace capture/readout controller.
// State encoding, status-register bit positions and read-source tags.
package ct_had_pipetrace_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CYC_W_DEF = 16;

  localparam int F_EN   = 0;
  localparam int F_IMM  = 1;
  localparam int F_ST   = 2;
  localparam int F_CNT  = 4;
  localparam int F_DONE = 12;
  localparam int F_OVR  = 13;
  localparam int F_ERR  = 14;
  localparam int F_CYC  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } pt_state_e;

  typedef enum logic [1:0] {
    RD_CTL  = 2'd0,
    RD_PIPE = 2'd1,
    RD_DBG  = 2'd2,
    RD_ERR  = 2'd3
  } rd_src_e;

endpackage

// File: rtl/ct_had_pipetrace_ctrl_if.sv
// JTAG DR / FIFO-side signal bundle of the pipe-trace controller.
// slave = controller view, master = surrounding HAD/FIFO view.
interface ct_had_pipetrace_ctrl_if;
  logic        x_sm_xx_update_dr_en;
  logic        x_sm_xx_capture_dr_en;
  logic        ir_xx_pipectl_reg_sel;
  logic        ir_xx_pipefifo_reg_sel;
  logic        ir_xx_dbgfifo_reg_sel;
  logic [63:0] ir_xx_wdata;
  logic        had_trace_trig;
  logic        rtu_had_xx_dbg_mode;
  logic [63:0] pipefifo_regs_data;
  logic [63:0] dbgfifo_regs_data;
  logic        ctrl_pipefifo_wen;
  logic        ctrl_pipefifo_ren;
  logic        ctrl_dbgfifo_ren;
  logic [31:0] pipectl_regs_data;
  logic        trace_rdata_vld;
  logic [63:0] trace_rdata;

  modport slave (
    input  x_sm_xx_update_dr_en, x_sm_xx_capture_dr_en,
    input  ir_xx_pipectl_reg_sel, ir_xx_pipefifo_reg_sel,
    input  ir_xx_dbgfifo_reg_sel, ir_xx_wdata,
    input  had_trace_trig, rtu_had_xx_dbg_mode,
    input  pipefifo_regs_data, dbgfifo_regs_data,
    output ctrl_pipefifo_wen, ctrl_pipefifo_ren, ctrl_dbgfifo_ren,
    output pipectl_regs_data, trace_rdata_vld, trace_rdata
  );

  modport master (
    output x_sm_xx_update_dr_en, x_sm_xx_capture_dr_en,
    output ir_xx_pipectl_reg_sel, ir_xx_pipefifo_reg_sel,
    output ir_xx_dbgfifo_reg_sel, ir_xx_wdata,
    output had_trace_trig, rtu_had_xx_dbg_mode,
    output pipefifo_regs_data, dbgfifo_regs_data,
    input  ctrl_pipefifo_wen, ctrl_pipefifo_ren, ctrl_dbgfifo_ren,
    input  pipectl_regs_data, trace_rdata_vld, trace_rdata
  );
endinterface

// File: rtl/ct_had_pipetrace_ctrl_rdseq.sv
// Two-stage DR-capture read sequencer: accept -> ren -> registered data/valid.
// One read in flight at a time; extra requests are dropped and flagged.
module ct_had_pipetrace_rdseq
  import ct_had_pipetrace_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        sel_pipe,
  input  logic        sel_dbg,
  input  logic        in_capture,
  input  logic [63:0] pipe_data,
  input  logic [63:0] dbg_data,
  input  logic [31:0] ctl_data,
  output logic        pipe_ren,
  output logic        dbg_ren,
  output logic        rdata_vld,
  output logic [63:0] rdata,
  output logic        err_set,
  output logic        ovr_set
);

  rd_src_e     src;
  rd_src_e     s1_src;
  logic        s1_vld;
  logic        accept;
  logic [63:0] mux;

  assign accept  = rd_req & ~s1_vld;
  assign ovr_set = rd_req & s1_vld;

  // Popping the pipe FIFO while it is being written is refused.
  always_comb begin
    src = RD_CTL;
    if (sel_pipe)
      src = in_capture ? RD_ERR : RD_PIPE;
    else if (sel_dbg)
      src = RD_DBG;
  end

  assign err_set  = accept & (src == RD_ERR);
  assign pipe_ren = s1_vld & (s1_src == RD_PIPE);
  assign dbg_ren  = s1_vld & (s1_src == RD_DBG);

  always_comb begin
    mux = '0;
    unique case (s1_src)
      RD_PIPE: mux = pipe_data;
      RD_DBG:  mux = dbg_data;
      RD_CTL:  mux = {32'b0, ctl_data};
      RD_ERR:  mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_src    <= RD_CTL;
      rdata_vld <= 1'b0;
      rdata     <= '0;
    end else begin
      s1_vld    <= accept;
      s1_src    <= src;
      rdata_vld <= s1_vld;
      rdata     <= s1_vld ? mux : '0;
    end
  end

endmodule

// File: rtl/ct_had_pipetrace_ctrl.sv
// HAD pipe-trace capture window FSM and status register, plus DR read sequencing.
// HAD_PIPETRACE_TRIG_EN enables the external trigger / ARMED state.
module ct_had_pipetrace_ctrl
  import ct_had_pipetrace_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input logic                   cpuclk,
  input logic                   cpurst,
  ct_had_pipetrace_ctrl_if.slave bus
);

  pt_state_e  state_q;
  pt_state_e  state_nxt;
  logic       en_q;
  logic       imm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_inc;
  logic       done_q;
  logic       err_q;
  logic       ovr_q;
  logic       err_set;
  logic       ovr_set;
  logic       ctl_wr;
  logic       wr_en;
  logic       wr_imm;
  logic [CNT_W-1:0] wr_cnt;
  logic       trig;
  logic       hit;
  logic       cap_end;
  logic [31:0] status;
  logic       unused_bits;

  assign ctl_wr = bus.x_sm_xx_update_dr_en & bus.ir_xx_pipectl_reg_sel;
  assign wr_en  = bus.ir_xx_wdata[F_EN];
  assign wr_cnt = bus.ir_xx_wdata[F_CNT+:CNT_W];

`ifdef HAD_PIPETRACE_TRIG_EN
  assign wr_imm = bus.ir_xx_wdata[F_IMM];
  assign trig   = bus.had_trace_trig;
  assign unused_bits = ^{bus.ir_xx_wdata[63:F_CNT+CNT_W],
                         bus.ir_xx_wdata[3:2]};
`else
  assign wr_imm = 1'b1;
  assign trig   = 1'b0;
  assign unused_bits = ^{bus.ir_xx_wdata[63:F_CNT+CNT_W],
                         bus.ir_xx_wdata[3:1], bus.had_trace_trig};
`endif

  assign cyc_inc = cyc_q + CYC_W'(1);
  assign hit     = (cnt_q != '0) && (cyc_inc == CYC_W'(cnt_q));

  // A control write overrides every other event this cycle.
  always_comb begin
    state_nxt = state_q;
    if (ctl_wr) begin
      if (!wr_en)
        state_nxt = ST_IDLE;
      else
        state_nxt = wr_imm ? ST_CAPTURE : ST_ARMED;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_nxt = ST_IDLE;
        ST_ARMED:   if (trig) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (hit || bus.rtu_had_xx_dbg_mode)
                      state_nxt = ST_DONE;
        ST_DONE:    state_nxt = ST_DONE;
      endcase
    end
  end

  assign cap_end = (state_q == ST_CAPTURE) && (state_nxt == ST_DONE);

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      imm_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (ctl_wr) begin
        en_q  <= wr_en;
        imm_q <= wr_imm;
        cnt_q <= wr_cnt;
      end
      if (ctl_wr && wr_en)
        cyc_q <= '0;
      else if (state_q == ST_CAPTURE && cyc_q != '1)
        cyc_q <= cyc_inc;
      if (ctl_wr && wr_en)
        done_q <= 1'b0;
      else if (cap_end)
        done_q <= 1'b1;
      if (err_set)
        err_q <= 1'b1;
      else if (ctl_wr)
        err_q <= 1'b0;
      if (ovr_set)
        ovr_q <= 1'b1;
      else if (ctl_wr)
        ovr_q <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[F_EN]          = en_q;
    status[F_IMM]         = imm_q;
    status[F_ST+:2]       = state_q;
    status[F_CNT+:CNT_W]  = cnt_q;
    status[F_DONE]        = done_q;
    status[F_OVR]         = ovr_q;
    status[F_ERR]         = err_q;
    status[F_CYC+:CYC_W]  = cyc_q;
  end

  assign bus.pipectl_regs_data = status;
  assign bus.ctrl_pipefifo_wen = (state_q == ST_CAPTURE);

  ct_had_pipetrace_rdseq u_rdseq (
    .clk        (cpuclk),
    .rst        (cpurst),
    .rd_req     (bus.x_sm_xx_capture_dr_en &
                 (bus.ir_xx_pipefifo_reg_sel |
                  bus.ir_xx_dbgfifo_reg_sel |
                  bus.ir_xx_pipectl_reg_sel)),
    .sel_pipe   (bus.ir_xx_pipefifo_reg_sel),
    .sel_dbg    (bus.ir_xx_dbgfifo_reg_sel),
    .in_capture (state_q == ST_CAPTURE),
    .pipe_data  (bus.pipefifo_regs_data),
    .dbg_data   (bus.dbgfifo_regs_data),
    .ctl_data   (status),
    .pipe_ren   (bus.ctrl_pipefifo_ren),
    .dbg_ren    (bus.ctrl_dbgfifo_ren),
    .rdata_vld  (bus.trace_rdata_vld),
    .rdata      (bus.trace_rdata),
    .err_set    (err_set),
    .ovr_set    (ovr_set)
  );

endmodule

// File: tb/tb_ct_had_pipetrace_ctrl.sv
// Directed bench for ct_had_pipetrace_ctrl: capture window, reads, sticky flags.
// Trigger-path vectors depend on HAD_PIPETRACE_TRIG_EN.
module tb_ct_had_pipetrace_ctrl;

  logic cpuclk = 1'b0;
  logic cpurst = 1'b1;

  always #5 cpuclk = ~cpuclk;

  ct_had_pipetrace_ctrl_if bus();

  ct_had_pipetrace_ctrl dut (
    .cpuclk (cpuclk),
    .cpurst (cpurst),
    .bus    (bus)
  );

  int nchk = 0;
  int nerr = 0;
  int n;
  logic [31:0] st;
  logic [63:0] d;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic ctl_wr(input logic en, input logic imm,
                        input logic [7:0] cnt);
    bus.x_sm_xx_update_dr_en  = 1'b1;
    bus.ir_xx_pipectl_reg_sel = 1'b1;
    bus.ir_xx_wdata = {52'b0, cnt, 2'b0, imm, en};
    step();
    bus.x_sm_xx_update_dr_en  = 1'b0;
    bus.ir_xx_pipectl_reg_sel = 1'b0;
    bus.ir_xx_wdata = '0;
  endtask

  // which: 0 ctl, 1 pipe, 2 dbg
  task automatic rd_go(input int which);
    bus.x_sm_xx_capture_dr_en  = 1'b1;
    bus.ir_xx_pipectl_reg_sel  = (which == 0);
    bus.ir_xx_pipefifo_reg_sel = (which == 1);
    bus.ir_xx_dbgfifo_reg_sel  = (which == 2);
    step();
    bus.x_sm_xx_capture_dr_en  = 1'b0;
    bus.ir_xx_pipectl_reg_sel  = 1'b0;
    bus.ir_xx_pipefifo_reg_sel = 1'b0;
    bus.ir_xx_dbgfifo_reg_sel  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout nchk=%0d", nchk);
    $fatal(1, "timeout");
  end

  initial begin
    bus.x_sm_xx_update_dr_en   = 1'b0;
    bus.x_sm_xx_capture_dr_en  = 1'b0;
    bus.ir_xx_pipectl_reg_sel  = 1'b0;
    bus.ir_xx_pipefifo_reg_sel = 1'b0;
    bus.ir_xx_dbgfifo_reg_sel  = 1'b0;
    bus.ir_xx_wdata            = '0;
    bus.had_trace_trig         = 1'b0;
    bus.rtu_had_xx_dbg_mode    = 1'b0;
    bus.pipefifo_regs_data     = '0;
    bus.dbgfifo_regs_data      = '0;
    cpurst = 1'b1;
    step();
    step();
    cpurst = 1'b0;
    step();
    chk("rst_wen", bus.ctrl_pipefifo_wen, 0);
    chk("rst_pren", bus.ctrl_pipefifo_ren, 0);
    chk("rst_dren", bus.ctrl_dbgfifo_ren, 0);
    chk("rst_vld", bus.trace_rdata_vld, 0);
    chk("rst_rdata", bus.trace_rdata, 0);
    chk("rst_stat", bus.pipectl_regs_data, 0);

    // CNT=5 immediate capture
    ctl_wr(1'b1, 1'b1, 8'd5);
    chk("c5_first", bus.ctrl_pipefifo_wen, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += int'(bus.ctrl_pipefifo_wen);
      step();
    end
    chk("c5_len", n, 5);
    chk("c5_stat", bus.pipectl_regs_data, 32'h0005_105F);

    // status readback through DR
    rd_go(0);
    chk("ctl_rd_pren", bus.ctrl_pipefifo_ren, 0);
    chk("ctl_rd_dren", bus.ctrl_dbgfifo_ren, 0);
    step();
    chk("ctl_rd_vld", bus.trace_rdata_vld, 1);
    chk("ctl_rd_data", bus.trace_rdata, 64'h0000_0000_0005_105F);

    // seven back-to-back dbgfifo reads in DONE
    for (int i = 0; i < 7; i++) begin
      d = 64'h0123_4567_89AB_0000 + 64'(i);
      bus.dbgfifo_regs_data = d;
      rd_go(2);
      chk("dbg_ren", bus.ctrl_dbgfifo_ren, 1);
      chk("dbg_novld", bus.trace_rdata_vld, 0);
      step();
      chk("dbg_vld", bus.trace_rdata_vld, 1);
      chk("dbg_data", bus.trace_rdata, d);
      chk("dbg_ren_off", bus.ctrl_dbgfifo_ren, 0);
    end
    step();

    // overlapping strobes: second one dropped
    bus.dbgfifo_regs_data = 64'hDEAD_BEEF_0000_0001;
    bus.x_sm_xx_capture_dr_en = 1'b1;
    bus.ir_xx_dbgfifo_reg_sel = 1'b1;
    step();
    chk("ovr_ren1", bus.ctrl_dbgfifo_ren, 1);
    step();
    bus.x_sm_xx_capture_dr_en = 1'b0;
    bus.ir_xx_dbgfifo_reg_sel = 1'b0;
    chk("ovr_vld1", bus.trace_rdata_vld, 1);
    chk("ovr_ren2", bus.ctrl_dbgfifo_ren, 0);
    step();
    chk("ovr_vld2", bus.trace_rdata_vld, 0);
    st = bus.pipectl_regs_data;
    chk("ovr_set", st[13], 1);
    ctl_wr(1'b0, 1'b0, 8'd0);
    st = bus.pipectl_regs_data;
    chk("ovr_clr", st[13], 0);
    chk("ovr_idle", st[3:2], 0);

    // CNT=1 boundary
    ctl_wr(1'b1, 1'b1, 8'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += int'(bus.ctrl_pipefifo_wen);
      step();
    end
    chk("c1_len", n, 1);

    // count reached together with dbg_mode
    ctl_wr(1'b1, 1'b1, 8'd2);
    step();
    bus.rtu_had_xx_dbg_mode = 1'b1;
    step();
    bus.rtu_had_xx_dbg_mode = 1'b0;
    chk("cd_wen", bus.ctrl_pipefifo_wen, 0);
    st = bus.pipectl_regs_data;
    chk("cd_stat", st, 32'h0002_102F);

`ifdef HAD_PIPETRACE_TRIG_EN
    ctl_wr(1'b1, 1'b0, 8'd0);
    st = bus.pipectl_regs_data;
    chk("arm_state", st[3:2], 1);
    step();
    step();
    chk("arm_wen", bus.ctrl_pipefifo_wen, 0);
    bus.had_trace_trig = 1'b1;
    step();
    bus.had_trace_trig = 1'b0;
    chk("trg_wen", bus.ctrl_pipefifo_wen, 1);
    n = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      n += int'(bus.ctrl_pipefifo_wen);
    end
    bus.rtu_had_xx_dbg_mode = 1'b1;
    step();
    bus.rtu_had_xx_dbg_mode = 1'b0;
    chk("dbgm_wen", bus.ctrl_pipefifo_wen, 0);
    chk("trg_len", n, 10);
    chk("trg_stat", bus.pipectl_regs_data, 32'h000A_100D);
`else
    ctl_wr(1'b1, 1'b0, 8'd3);
    chk("nt_wen", bus.ctrl_pipefifo_wen, 1);
    st = bus.pipectl_regs_data;
    chk("nt_stat", st[3:0], 4'hB);
    bus.had_trace_trig = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.had_trace_trig = 1'b0;
    chk("nt_stat2", bus.pipectl_regs_data, 32'h0003_103F);
`endif

    // pipe read while capturing is refused
    ctl_wr(1'b1, 1'b1, 8'd0);
    bus.pipefifo_regs_data = 64'hFFFF_0000_FFFF_0000;
    rd_go(1);
    chk("err_pren", bus.ctrl_pipefifo_ren, 0);
    step();
    chk("err_vld", bus.trace_rdata_vld, 1);
    chk("err_data", bus.trace_rdata, 0);
    st = bus.pipectl_regs_data;
    chk("err_set", st[14], 1);

    // disable write beats trigger
    ctl_wr(1'b1, 1'b0, 8'd0);
    bus.had_trace_trig = 1'b1;
    ctl_wr(1'b0, 1'b0, 8'd0);
    bus.had_trace_trig = 1'b0;
    chk("dis_wen", bus.ctrl_pipefifo_wen, 0);
    st = bus.pipectl_regs_data;
    chk("dis_state", st[3:2], 0);
    chk("err_clr", st[14], 0);
    step();
    chk("dis_wen2", bus.ctrl_pipefifo_wen, 0);

    // pipe read outside capture
    bus.pipefifo_regs_data = 64'h1111_2222_3333_4444;
    rd_go(1);
    chk("pipe_ren", bus.ctrl_pipefifo_ren, 1);
    step();
    chk("pipe_data", bus.trace_rdata, 64'h1111_2222_3333_4444);

    // read strobe and control write together
    bus.dbgfifo_regs_data = 64'hCAFE_F00D_1234_5678;
    bus.x_sm_xx_capture_dr_en = 1'b1;
    bus.ir_xx_dbgfifo_reg_sel = 1'b1;
    ctl_wr(1'b1, 1'b1, 8'd3);
    bus.x_sm_xx_capture_dr_en = 1'b0;
    bus.ir_xx_dbgfifo_reg_sel = 1'b0;
    chk("both_ren", bus.ctrl_dbgfifo_ren, 1);
    chk("both_wen", bus.ctrl_pipefifo_wen, 1);
    step();
    chk("both_data", bus.trace_rdata, 64'hCAFE_F00D_1234_5678);
    for (int i = 0; i < 4; i++) step();

    // reset during a read
    rd_go(2);
    chk("mrst_ren", bus.ctrl_dbgfifo_ren, 1);
    cpurst = 1'b1;
    step();
    chk("mrst_vld", bus.trace_rdata_vld, 0);
    chk("mrst_ren2", bus.ctrl_dbgfifo_ren, 0);
    chk("mrst_stat", bus.pipectl_regs_data, 0);
    cpurst = 1'b0;
    step();
    chk("mrst_vld2", bus.trace_rdata_vld, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
